// File: rtl/tone_decoder.sv
// tone_decoder
//   Measures the period of an incoming square wave on sys_clk and decodes it
//   into the 12-bit {high, med, low} note code used by the score ROM. The
//   reference table is fixed for a 100 MHz sys_clk.
//
//   Optional build macro: TONE_DEC_GLITCH_FILTER_EN
//     defined   - the synchronized input only changes level after holding the
//                 new value for FILTER_LEN consecutive cycles (edge latency
//                 becomes 3 + FILTER_LEN cycles).
//     undefined - the synchronizer output feeds edge detect directly.
//
//   Ports
//     sys_clk      in   system clock
//     rst          in   synchronous active-high reset (clears every flop)
//     tone_in      in   asynchronous square-wave input
//     note_code    out  {high[11:8], med[7:4], low[3:0]}, one nibble 1..7 or all 0
//     note_valid   out  note_code holds a confirmed note
//     new_note     out  one-cycle pulse when note_code takes a new confirmed value
//     period       out  last measured period in sys_clk cycles
//     period_valid out  one-cycle pulse when period updates
//
//   state  | meaning
//   IDLE   | no tone; waiting for the first rising edge
//   ARMED  | counting cycles since the last edge; next edge captures a period
//   SEARCH | comparing the captured period to one table entry per cycle
//   DECIDE | updating the match streak and, when stable, the reported note
module tone_decoder #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned STABLE_CNT  = 3,
  parameter int unsigned FILTER_LEN  = 16
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [11:0] note_code,
  output logic        note_valid,
  output logic        new_note,
  output logic [19:0] period,
  output logic        period_valid
);

  typedef enum logic [1:0] {IDLE, ARMED, SEARCH, DECIDE} state_t;

  localparam logic [19:0] TIMEOUT_V = 20'(TIMEOUT_CYC);
  localparam logic [3:0]  STABLE_V  = 4'(STABLE_CNT);
  localparam logic [4:0]  LAST_IDX  = 5'd20;

  // CLK_HZ is documentation only; FILTER_LEN is idle in the default build.
  logic unused_cfg;
  assign unused_cfg = ^{CLK_HZ, FILTER_LEN};

  state_t      state;
  logic        sync1, sync2, lvl, lvl_d, rise;
  logic [19:0] cnt;
  logic [4:0]  idx, hit_idx, cand;
  logic        hit, cand_ok;
  logic [3:0]  streak, streak_nxt;
  logic [19:0] ref_cur;
  logic signed [20:0] diff;
  logic [20:0] adiff, tol;
  logic        match;
  logic [11:0] hit_code;

  function automatic logic [19:0] ref_period(input logic [4:0] i);
    ref_period = 20'd0;
    case (i)
      5'd0:  ref_period = 20'd382219;
      5'd1:  ref_period = 20'd340529;
      5'd2:  ref_period = 20'd303370;
      5'd3:  ref_period = 20'd286344;
      5'd4:  ref_period = 20'd255102;
      5'd5:  ref_period = 20'd227273;
      5'd6:  ref_period = 20'd202478;
      5'd7:  ref_period = 20'd191110;
      5'd8:  ref_period = 20'd170265;
      5'd9:  ref_period = 20'd151685;
      5'd10: ref_period = 20'd143172;
      5'd11: ref_period = 20'd127551;
      5'd12: ref_period = 20'd113636;
      5'd13: ref_period = 20'd101239;
      5'd14: ref_period = 20'd95555;
      5'd15: ref_period = 20'd85132;
      5'd16: ref_period = 20'd75843;
      5'd17: ref_period = 20'd71586;
      5'd18: ref_period = 20'd63776;
      5'd19: ref_period = 20'd56818;
      5'd20: ref_period = 20'd50619;
      default: ref_period = 20'd0;
    endcase
  endfunction

  // Table index to note code: 0..6 low nibble, 7..13 med, 14..20 high.
  function automatic logic [11:0] idx_code(input logic [4:0] i);
    idx_code = 12'h000;
    if (i < 5'd7)       idx_code = {8'h00, 1'b0, 3'(i + 5'd1)};
    else if (i < 5'd14) idx_code = {4'h0, 1'b0, 3'(i - 5'd6), 4'h0};
    else if (i < 5'd21) idx_code = {1'b0, 3'(i - 5'd13), 8'h00};
  endfunction

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      lvl_d <= lvl;
    end
  end

`ifdef TONE_DEC_GLITCH_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic [FW-1:0] flt_cnt;
  logic          flt;

  // flt_cnt counts consecutive cycles the input disagrees with flt; any
  // agreement restarts the count, so short spikes never reach the level.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      flt     <= 1'b0;
      flt_cnt <= '0;
    end else if (sync2 == flt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      flt     <= sync2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FW'(1);
    end
  end

  assign lvl = flt;
`else
  assign lvl = sync2;
`endif

  assign rise = lvl & ~lvl_d;

  // Tolerance window |period - ref| <= ref/32, with a 21-bit signed difference
  // so the 20-bit operands cannot overflow.
  assign ref_cur  = ref_period(idx);
  assign diff     = $signed({1'b0, period}) - $signed({1'b0, ref_cur});
  assign adiff    = diff[20] ? 21'(-diff) : 21'(diff);
  assign tol      = {6'd0, ref_cur[19:5]};
  assign match    = (adiff <= tol);
  assign hit_code = idx_code(hit_idx);

  always_comb begin
    streak_nxt = 4'd1;
    if (cand_ok && (cand == hit_idx))
      streak_nxt = (streak == 4'hF) ? streak : streak + 4'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 20'd0;
      idx          <= 5'd0;
      hit          <= 1'b0;
      hit_idx      <= 5'd0;
      cand         <= 5'd0;
      cand_ok      <= 1'b0;
      streak       <= 4'd0;
      note_code    <= 12'h000;
      note_valid   <= 1'b0;
      new_note     <= 1'b0;
      period       <= 20'd0;
      period_valid <= 1'b0;
    end else begin
      new_note     <= 1'b0;
      period_valid <= 1'b0;
      // cnt stops at TIMEOUT_CYC: that value is the tone-loss condition.
      if ((state != IDLE) && (cnt == TIMEOUT_V)) begin
        state      <= IDLE;
        cnt        <= 20'd0;
        note_valid <= 1'b0;
        note_code  <= 12'h000;
        streak     <= 4'd0;
        cand_ok    <= 1'b0;
        cand       <= 5'd0;
      end else begin
        if (rise)
          cnt <= 20'd1;
        else if (state != IDLE)
          cnt <= cnt + 20'd1;

        case (state)
          IDLE: begin
            if (rise) state <= ARMED;
          end
          ARMED: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              idx          <= 5'd0;
              state        <= SEARCH;
            end
          end
          SEARCH: begin
            // A new edge mid-search means the captured period is unusable.
            if (rise) begin
              streak  <= 4'd0;
              cand_ok <= 1'b0;
              cand    <= 5'd0;
              state   <= ARMED;
            end else if (match) begin
              hit     <= 1'b1;
              hit_idx <= idx;
              state   <= DECIDE;
            end else if (idx == LAST_IDX) begin
              hit     <= 1'b0;
              state   <= DECIDE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
          DECIDE: begin
            state <= ARMED;
            if (hit) begin
              streak  <= streak_nxt;
              cand    <= hit_idx;
              cand_ok <= 1'b1;
              if ((streak_nxt >= STABLE_V) && (!note_valid || (hit_code != note_code))) begin
                note_code  <= hit_code;
                note_valid <= 1'b1;
                new_note   <= 1'b1;
              end
            end else begin
              streak  <= 4'd0;
              cand_ok <= 1'b0;
              cand    <= 5'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
